hamming_secded_decoder_pipe: RTL and testbench
==============================================

// Module: hamming_secded_decoder_pipe
// PURPOSE
//  Parametrised, pipelined SEC-DED decoder: extended Hamming code (Hamming plus overall parity).
//  Corrects single-bit errors and flags double-bit errors on a K-bit data word.
//  Uses a valid/ready stream interface with backpressure.
//  Sits between TMR/RAM readback and the consumer, e.g. on FIFO outputs and on configuration-memory scrubbing paths.
// PARAMETERS
//  K      32  information bits per word (K >= 4)
//  R      localparam  smallest R with 2**R >= K+R+1 (K=4 -> 3, K=8 -> 4, K=32 -> 6)
//  N      localparam  codeword width = K+R+1
//  CNT_W  16  width of the error statistics counters
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      synchronous, active-high reset
//  code_i         in   N      received codeword
//  code_valid_i   in   1      code_i is valid
//  code_ready_o   out  1      decoder accepts code_i this cycle
//  data_o         out  K      corrected data
//  data_valid_o   out  1      data_o and the flags are valid
//  data_ready_i   in   1      consumer accepts data_o
//  sec_o          out  1      single error corrected (qualified by data_valid_o)
//  ded_o          out  1      uncorrectable error detected (qualified by data_valid_o)
//  cnt_clear_i    in   1      synchronous clear of both counters
//  sec_cnt_o      out  CNT_W  saturating count of delivered words with sec_o=1
//  ded_cnt_o      out  CNT_W  saturating count of delivered words with ded_o=1
// BEHAVIOUR
//  - Codeword layout:
//    - code_i[0] is the overall parity bit.
//    - code_i[i] for i = 1..N-1 is Hamming position i.
//    - Check bits sit at power-of-2 positions.
//    - Data bits fill the remaining positions in ascending order, data bit 0 at position 3.
//  - Stage 1 (registered): syndrome s[R-1:0], where s[j] = XOR of code bits at positions with bit j set.
//    Overall parity p = XOR of all N bits. The codeword is registered alongside.
//  - Stage 2 (registered): classification.
//    - s==0, p==0: clean; sec=0, ded=0.
//    - p==1, s<=N-1: single error at position s (s==0 means parity bit); flip that bit; sec=1.
//    - p==1, s>N-1: invalid position; ded=1, data passed uncorrected.
//    - s!=0, p==0: double error; ded=1, data passed uncorrected.
//  - Latency: 2 cycles from input handshake to data_valid_o with no stall. Throughput: 1 word/cycle.
//  - Handshake:
//    - Input transfer on code_valid_i & code_ready_o; output transfer on data_valid_o & data_ready_i.
//    - Global stall: stall = data_valid_o & ~data_ready_i.
//    - code_ready_o = ~stall. Both stages hold their contents while stalled.
//    - data_o, sec_o and ded_o stay stable while data_valid_o=1 and data_ready_i=0.
//    - Pipeline bubbles (stage valid=0) advance even during stall only if downstream is empty; otherwise hold.
//  - Counters:
//    - Increment only on an output transfer, so a stalled word is counted once.
//    - Saturate at 2**CNT_W-1.
//    - cnt_clear_i wins over a simultaneous increment: the counter goes to 0 and that event is dropped.
//  - Reset: all stage valids and data_valid_o=0, data_o=0, sec_o=0, ded_o=0, counters=0.
//    In-flight words are discarded. code_ready_o=1 in the cycle after reset deasserts.
// CONFIGURATION
//  HAMMING_SECDED_STATS_EN
//  - Defined: counter logic present as above.
//  - Undefined: sec_cnt_o and ded_cnt_o are tied to 0, cnt_clear_i is ignored, and no counter flops are inferred.
//  - Datapath and flags are identical in both builds.
// TESTING (K=8, N=13, data 0xA5 encoded as C)
//  - Stream C for 10 cycles, data_ready_i=1 -> data_o=0xA5, sec=0, ded=0; first data_valid_o 2 cycles after first accept.
//  - C with bit 6 flipped -> data_o=0xA5, sec_o=1, ded_o=0. Same for bit 0 (parity) and bit 12 (last data).
//  - C with bits 3 and 9 flipped -> ded_o=1, sec_o=0, data_o = uncorrected extraction.
//  - data_ready_i=0 for 5 cycles with 3 words queued -> code_ready_o=0, data_o stable.
//    On release, 3 words arrive in order and sec_cnt increments once per word.
//  - CNT_W=2, 5 single-error words -> sec_cnt_o saturates at 3.
//    cnt_clear_i in the same cycle as a ded word -> ded_cnt_o=0.
//  - rst_i pulsed with 2 words in flight -> data_valid_o=0 next cycle, counters 0, in-flight words never delivered.
//    Repeat with HAMMING_SECDED_STATS_EN undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/hamming_secded_decoder_pipe_if.sv
// hamming_secded_decoder_pipe_if: valid/ready codeword stream in, corrected data with SEC/DED flags out
interface hamming_secded_decoder_pipe_if #(parameter int K = 32);
  function automatic int calc_r(int k);
    int r = 1;
    while ((1 << r) < k + r + 1) r++;
    return r;
  endfunction
  localparam int R = calc_r(K);
  localparam int N = K + R + 1;
  logic [N-1:0] code_i;
  logic code_valid_i, code_ready_o;
  logic [K-1:0] data_o;
  logic data_valid_o, data_ready_i, sec_o, ded_o;
  modport slave(input code_i, code_valid_i, data_ready_i, output code_ready_o, data_o, data_valid_o, sec_o, ded_o);
  modport master(output code_i, code_valid_i, data_ready_i, input code_ready_o, data_o, data_valid_o, sec_o, ded_o);
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// hamming_secded_decoder_pipe: two-stage extended-Hamming SEC-DED decoder; HAMMING_SECDED_STATS_EN adds error counters
module hamming_secded_decoder_pipe #(
  parameter int K = 32,
  parameter int CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  hamming_secded_decoder_pipe_if.slave bus,
  input  logic cnt_clear_i,
  output logic [CNT_W-1:0] sec_cnt_o,
  output logic [CNT_W-1:0] ded_cnt_o
);
  function automatic int calc_r(int k);
    int r = 1;
    while ((1 << r) < k + r + 1) r++;
    return r;
  endfunction
  // Hamming position of data bit d: the d-th non-power-of-2 position from 3 upwards
  function automatic int data_pos(int d);
    int p = 2;
    int n = -1;
    while (n < d) begin
      p++;
      if ((p & (p - 1)) != 0) n++;
    end
    return p;
  endfunction
  localparam int R = calc_r(K);
  localparam int N = K + R + 1;
  localparam logic [R-1:0] last_pos = R'(N - 1);
  logic stall;
  logic [R-1:0] syn, s1;
  logic par, p1, v1;
  logic [N-1:0] c1, fixed;
  logic [K-1:0] data_x;
  logic flip, bad;
  assign stall = bus.data_valid_o & ~bus.data_ready_i;
  assign bus.code_ready_o = ~stall;
  assign par = ^bus.code_i;
  always_comb begin
    syn = '0;
    for (int i = 1; i < N; i++)
      for (int j = 0; j < R; j++)
        if (((i >> j) & 1) != 0) syn[j] = syn[j] ^ bus.code_i[i];
  end
  // Syndrome beyond the last position with odd parity cannot be a single error
  assign flip = p1 & (s1 <= last_pos);
  assign bad = p1 ? ~flip : (s1 != '0);
  assign fixed = c1 ^ (flip ? (N'(1) << s1) : '0);
  for (genvar g = 0; g < K; g++) begin : g_extract
    assign data_x[g] = fixed[data_pos(g)];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1 <= 1'b0;
      bus.data_valid_o <= 1'b0;
      bus.data_o <= '0;
      bus.sec_o <= 1'b0;
      bus.ded_o <= 1'b0;
    end else if (!stall) begin
      v1 <= bus.code_valid_i;
      bus.data_valid_o <= v1;
      bus.data_o <= data_x;
      bus.sec_o <= flip;
      bus.ded_o <= bad;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!stall) begin
      c1 <= bus.code_i;
      s1 <= syn;
      p1 <= par;
    end
  end
`ifdef HAMMING_SECDED_STATS_EN
  logic xfer;
  assign xfer = bus.data_valid_o & bus.data_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clear_i) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
    end else begin
      if (xfer && bus.sec_o && !(&sec_cnt_o)) sec_cnt_o <= sec_cnt_o + CNT_W'(1);
      if (xfer && bus.ded_o && !(&ded_cnt_o)) ded_cnt_o <= ded_cnt_o + CNT_W'(1);
    end
  end
`else
  logic unused_clear;
  assign unused_clear = cnt_clear_i;
  assign sec_cnt_o = '0;
  assign ded_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// tb_hamming_secded_decoder_pipe: directed vectors for the K=8 SEC-DED decoder pipeline, with CNT_W=2 counters
module tb_hamming_secded_decoder_pipe;
  localparam int K = 8;
  localparam int N = 13;
  localparam int CNT_W = 2;
`ifdef HAMMING_SECDED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  // 0xA5 and 0xFF encoded by hand
  localparam logic [N-1:0] C = 13'h144E;
  localparam logic [N-1:0] F = 13'h1EEE;
  typedef struct {
    logic [N-1:0] code;
    logic [K-1:0] data;
    logic sec;
    logic ded;
  } vec_t;
  vec_t vecs[10];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cnt_clear = 1'b0;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;
  logic [K-1:0] d;
  logic s, e;
  bit ok;
  int checks = 0;
  int errors = 0;
  int k;
  hamming_secded_decoder_pipe_if #(.K(K)) bus();
  hamming_secded_decoder_pipe #(.K(K), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .cnt_clear_i(cnt_clear), .sec_cnt_o(sec_cnt), .ded_cnt_o(ded_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] cexp(int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_one(input logic [N-1:0] code, output logic [K-1:0] dd, output logic ss, output logic ee, output bit got);
    bus.code_i = code;
    bus.code_valid_i = 1'b1;
    tick();
    bus.code_valid_i = 1'b0;
    got = 1'b0;
    dd = '0; ss = 1'b0; ee = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (bus.data_valid_o) begin
        got = 1'b1;
        dd = bus.data_o; ss = bus.sec_o; ee = bus.ded_o;
      end
    end
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{C, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{C ^ 13'h0040, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{C ^ 13'h0001, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{C ^ 13'h1000, 8'hA5, 1'b1, 1'b0};
    vecs[4] = '{C ^ 13'h0208, 8'hB4, 1'b0, 1'b1};
    vecs[5] = '{C ^ 13'h0112, 8'hA5, 1'b0, 1'b1};
    vecs[6] = '{13'h0000, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{F ^ 13'h0002, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{C ^ 13'h0021, 8'hA7, 1'b0, 1'b1};
    vecs[9] = '{F ^ 13'h0008, 8'hFF, 1'b1, 1'b0};
    bus.code_i = '0;
    bus.code_valid_i = 1'b0;
    bus.data_ready_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.data_valid_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_flags", {bus.sec_o, bus.ded_o}, 0);
    chk("rst_cnt", {sec_cnt, ded_cnt}, 0);
    chk("rst_ready", bus.code_ready_o, 1);
    tick();
    for (int i = 0; i < 10; i++) begin
      send_one(vecs[i].code, d, s, e, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_data", i), d, vecs[i].data);
      chk($sformatf("vec%0d_sec", i), s, vecs[i].sec);
      chk($sformatf("vec%0d_ded", i), e, vecs[i].ded);
    end
    // back-to-back stream: output valid exactly two cycles behind input
    bus.code_i = C;
    bus.code_valid_i = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chk($sformatf("stream_valid%0d", c), bus.data_valid_o, (c >= 2 && c < 12) ? 1 : 0);
      if (c >= 2 && c < 12) chk($sformatf("stream_data%0d", c), {bus.data_o, bus.sec_o, bus.ded_o}, {8'hA5, 2'b00});
      tick();
      if (c == 9) bus.code_valid_i = 1'b0;
    end
    // backpressure with three words queued
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    bus.data_ready_i = 1'b0;
    bus.code_valid_i = 1'b1;
    bus.code_i = C ^ 13'h0040;
    tick();
    bus.code_i = F ^ 13'h0002;
    tick();
    bus.code_i = C ^ 13'h1000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_ready%0d", i), bus.code_ready_o, 0);
      chk($sformatf("stall_out%0d", i), {bus.data_valid_o, bus.data_o, bus.sec_o}, {1'b1, 8'hA5, 1'b1});
      chk($sformatf("stall_cnt%0d", i), sec_cnt, 0);
      tick();
    end
    bus.data_ready_i = 1'b1;
    @(negedge clk);
    chk("release_ready", bus.code_ready_o, 1);
    chk("release_w0", {bus.data_valid_o, bus.data_o}, {1'b1, 8'hA5});
    tick();
    bus.code_valid_i = 1'b0;
    k = 1;
    for (int i = 0; i < 6 && k < 3; i++) begin
      @(negedge clk);
      if (bus.data_valid_o) begin
        chk($sformatf("release_w%0d", k), {bus.data_o, bus.sec_o}, {(k == 1) ? 8'hFF : 8'hA5, 1'b1});
        chk($sformatf("release_cnt%0d", k), sec_cnt, cexp(k));
        k++;
      end
      tick();
    end
    chk("release_count", k, 3);
    @(negedge clk);
    chk("release_cnt_final", sec_cnt, cexp(3));
    tick();
    // saturation at 2**CNT_W-1
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_one(vecs[1].code, d, s, e, ok);
      if (i == 1) chk("sat_cnt2", sec_cnt, cexp(2));
    end
    chk("sat_cnt", sec_cnt, cexp(3));
    // reset with two words in flight
    bus.data_ready_i = 1'b0;
    bus.code_valid_i = 1'b1;
    bus.code_i = C ^ 13'h0040;
    tick();
    bus.code_i = C ^ 13'h1000;
    tick();
    bus.code_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus.data_valid_o, 0);
    chk("mid_rst_out", {bus.data_o, bus.sec_o, bus.ded_o}, 0);
    chk("mid_rst_cnt", sec_cnt, 0);
    chk("mid_rst_ready", bus.code_ready_o, 1);
    bus.data_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_drop%0d", i), bus.data_valid_o, 0);
      tick();
    end
    // clear coinciding with a DED delivery drops that event
    send_one(vecs[4].code, d, s, e, ok);
    chk("ded_cnt1", ded_cnt, cexp(1));
    bus.code_i = vecs[4].code;
    bus.code_valid_i = 1'b1;
    tick();
    bus.code_valid_i = 1'b0;
    tick();
    cnt_clear = 1'b1;
    @(negedge clk);
    chk("clr_ded_word", {bus.data_valid_o, bus.ded_o}, 2'b11);
    tick();
    cnt_clear = 1'b0;
    @(negedge clk);
    chk("clr_ded_cnt", ded_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
